// File: rtl/harness_pkg.sv
// Shared types and constants for the SimpleCPU harness controller.
// Holds the controller state enum, the dump sequencer phase enum, the
// mem_sel encodings and the helper that sizes the memory index.
package harness_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IM,
        S_LOAD_RF,
        S_LOAD_DM,
        S_RUN,
        S_DUMP_RF,
        S_DUMP_DM,
        S_DONE
    } state_t;

    // RD presents the address, HOLD offers the beat until it is taken.
    typedef enum logic {
        PH_RD,
        PH_HOLD
    } phase_t;

    localparam logic [1:0] MEM_SEL_IM   = 2'd0;
    localparam logic [1:0] MEM_SEL_RF   = 2'd1;
    localparam logic [1:0] MEM_SEL_DM   = 2'd2;
    localparam logic [1:0] MEM_SEL_NONE = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Index width able to address the deepest of the three memories.
    function automatic int idx_w(input int a, input int b, input int c);
        int m;
        m = max3(a, b, c);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/harness_dump_unit.sv
// Dump sequencer: walks entries 0..last_idx of the selected memory, two
// phases per entry (RD then HOLD), and offers each entry on dp_* with a
// valid/ready handshake.
// Ports: en (active while a dump state is selected), byte_mode (zero-extend
// [7:0]), last_idx, mem_rdata in; addr, dp_valid, dp_data, last_beat out.
module harness_dump_unit
    import harness_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MA_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              byte_mode,
    input  logic [MA_W-1:0]   last_idx,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              dp_ready,
    output logic [MA_W-1:0]   addr,
    output logic              dp_valid,
    output logic [DATA_W-1:0] dp_data,
    output logic              last_beat
);

    phase_t            phase;
    logic              first;
    logic [MA_W-1:0]   idx;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rdata_ext;

    always_comb begin
        rdata_ext = mem_rdata;
        if (byte_mode) rdata_ext = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
    end

    // Read data arrives in the first HOLD cycle; pass it straight through
    // then, and serve the captured copy for any later stalled cycles.
    assign addr      = idx;
    assign dp_valid  = en && (phase == PH_HOLD);
    assign dp_data   = first ? rdata_ext : hold_q;
    assign last_beat = dp_valid && dp_ready && (idx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= PH_RD;
            first  <= 1'b0;
            idx    <= '0;
            hold_q <= '0;
        end else if (!en) begin
            phase <= PH_RD;
            first <= 1'b0;
            idx   <= '0;
        end else if (phase == PH_RD) begin
            phase <= PH_HOLD;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            if (first) hold_q <= rdata_ext;
            if (dp_ready) begin
                phase <= PH_RD;
                idx   <= (idx == last_idx) ? '0 : idx + MA_W'(1);
            end
        end
    end

endmodule

// File: rtl/sim_harness_ctrl.sv
// Load/run/dump controller for the SimpleCPU harness.
// Loads IM, RF and DM from the ld_* stream, steps the CPU PC until it nears
// the end of IM or the cycle budget runs out, then streams RF and DM on dp_*.
// Ports: start/busy/done/timeout control; ld_* load stream; mem_* memory
// port (we/sel/addr/wdata out, rdata in); cpu_pc_in/cpu_pc_out/cpu_run CPU
// link; dp_* dump stream.
module sim_harness_ctrl
    import harness_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int IM_BYTES   = 128,
    parameter int RF_WORDS   = 32,
    parameter int DM_BYTES   = 128,
    parameter int STEP_BYTES = 4,
    parameter int MAX_CYCLES = 1024,
    parameter int MA_W       = idx_w(IM_BYTES, RF_WORDS, DM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              mem_we,
    output logic [1:0]        mem_sel,
    output logic [MA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] cpu_pc_in,
    output logic [ADDR_W-1:0] cpu_pc_out,
    output logic              cpu_run,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [DATA_W-1:0] dp_data
);

    localparam int                CYC_W   = $clog2(MAX_CYCLES + 1);
    localparam logic [MA_W-1:0]   IM_LAST = MA_W'(IM_BYTES - 1);
    localparam logic [MA_W-1:0]   RF_LAST = MA_W'(RF_WORDS - 1);
    localparam logic [MA_W-1:0]   DM_LAST = MA_W'(DM_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STOP = ADDR_W'(IM_BYTES - STEP_BYTES);
    localparam logic [CYC_W-1:0]  CYC_END = CYC_W'(MAX_CYCLES - 1);

    state_t            state, next;
    logic [MA_W-1:0]   idx;
    logic [MA_W-1:0]   load_last;
    logic [CYC_W-1:0]  cyc;
    logic [ADDR_W-1:0] pc;
    logic              set_timeout;
    logic              dump_en, byte_mode, dump_fin;
    logic [MA_W-1:0]   dump_last, dump_addr;

    assign busy       = !(state == S_IDLE || state == S_DONE);
    assign done       = (state == S_DONE);
    assign cpu_pc_out = pc;
    assign mem_wdata  = ld_data;

    always_comb begin
        next        = state;
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = MEM_SEL_NONE;
        mem_addr    = '0;
        load_last   = '0;
        cpu_run     = 1'b0;
        set_timeout = 1'b0;
        dump_en     = 1'b0;
        dump_last   = '0;
        byte_mode   = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) next = S_LOAD_IM;
            S_LOAD_IM: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_sel   = MEM_SEL_IM;
                mem_addr  = idx;
                load_last = IM_LAST;
                if (ld_valid && idx == IM_LAST) next = S_LOAD_RF;
            end
            S_LOAD_RF: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_sel   = MEM_SEL_RF;
                mem_addr  = idx;
                load_last = RF_LAST;
                if (ld_valid && idx == RF_LAST) next = S_LOAD_DM;
            end
            S_LOAD_DM: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_sel   = MEM_SEL_DM;
                mem_addr  = idx;
                load_last = DM_LAST;
                if (ld_valid && idx == DM_LAST) next = S_RUN;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                // PC exit is checked first so it wins over the budget.
                if (pc >= PC_STOP) begin
                    next = S_DUMP_RF;
                end else if (cyc == CYC_END) begin
                    next        = S_DUMP_RF;
                    set_timeout = 1'b1;
                end
            end
            S_DUMP_RF: begin
                dump_en   = 1'b1;
                dump_last = RF_LAST;
                mem_sel   = MEM_SEL_RF;
                mem_addr  = dump_addr;
                if (dump_fin) next = S_DUMP_DM;
            end
            S_DUMP_DM: begin
                dump_en   = 1'b1;
                dump_last = DM_LAST;
                byte_mode = 1'b1;
                mem_sel   = MEM_SEL_DM;
                mem_addr  = dump_addr;
                if (dump_fin) next = S_DONE;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            cyc     <= '0;
            pc      <= '0;
            timeout <= 1'b0;
        end else begin
            state <= next;
            if (ld_ready && ld_valid)
                idx <= (idx == load_last) ? '0 : idx + MA_W'(1);
            // PC only follows the CPU while RUN continues, so on exit it
            // still shows the value that ended the run.
            if (state != S_RUN && next == S_RUN) begin
                pc  <= '0;
                cyc <= '0;
            end else if (state == S_RUN && next == S_RUN) begin
                pc  <= cpu_pc_in;
                cyc <= cyc + CYC_W'(1);
            end
            if (start && (state == S_IDLE || state == S_DONE)) timeout <= 1'b0;
            else if (set_timeout)                               timeout <= 1'b1;
        end
    end

    harness_dump_unit #(.DATA_W(DATA_W), .MA_W(MA_W)) u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (dump_en),
        .byte_mode (byte_mode),
        .last_idx  (dump_last),
        .mem_rdata (mem_rdata),
        .dp_ready  (dp_ready),
        .addr      (dump_addr),
        .dp_valid  (dp_valid),
        .dp_data   (dp_data),
        .last_beat (dump_fin)
    );

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Bench for sim_harness_ctrl. Instance 0 uses the default 1024-cycle budget
// with a CPU that advances PC by 4; instance 1 uses a 16-cycle budget with a
// CPU stuck at PC 8. Memories are modelled here with a one-cycle read.
module tb_sim_harness_ctrl;

    localparam int N_IM = 128, N_RF = 32, N_DM = 128, N_ALL = 288;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start[2], busy[2], done[2], timeout[2];
    logic        ld_valid[2], ld_ready[2], mem_we[2], cpu_run[2];
    logic        dp_valid[2], dp_ready[2];
    logic [31:0] ld_data[2], mem_wdata[2], cpu_pc_in[2], cpu_pc_out[2], dp_data[2];
    logic [31:0] mem_rdata[2] = '{32'd0, 32'd0};
    logic [1:0]  mem_sel[2];
    logic [6:0]  mem_addr[2];

    int total = 0, bad = 0;
    logic [31:0] beats[N_ALL];

    always #5 clk = ~clk;

    assign cpu_pc_in[0] = cpu_pc_out[0] + 32'd4;
    assign cpu_pc_in[1] = 32'd8;

    sim_harness_ctrl #(.MAX_CYCLES(1024)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .timeout(timeout[0]), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .ld_data(ld_data[0]), .mem_we(mem_we[0]), .mem_sel(mem_sel[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .cpu_pc_in(cpu_pc_in[0]), .cpu_pc_out(cpu_pc_out[0]), .cpu_run(cpu_run[0]),
        .dp_valid(dp_valid[0]), .dp_ready(dp_ready[0]), .dp_data(dp_data[0])
    );

    sim_harness_ctrl #(.MAX_CYCLES(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .timeout(timeout[1]), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .ld_data(ld_data[1]), .mem_we(mem_we[1]), .mem_sel(mem_sel[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .cpu_pc_in(cpu_pc_in[1]), .cpu_pc_out(cpu_pc_out[1]), .cpu_run(cpu_run[1]),
        .dp_valid(dp_valid[1]), .dp_ready(dp_ready[1]), .dp_data(dp_data[1])
    );

    // Memory models plus write / done-edge counters.
    logic [7:0]  im[2][N_IM];
    logic [31:0] rf[2][N_RF];
    logic [7:0]  dm[2][N_DM];
    int   wr_cnt[2]     = '{0, 0};
    int   done_rises[2] = '{0, 0};
    logic done_q[2]     = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mem_we[u]) begin
                wr_cnt[u] <= wr_cnt[u] + 1;
                case (mem_sel[u])
                    2'd0:    im[u][mem_addr[u]]      <= mem_wdata[u][7:0];
                    2'd1:    rf[u][mem_addr[u][4:0]] <= mem_wdata[u];
                    2'd2:    dm[u][mem_addr[u]]      <= mem_wdata[u][7:0];
                    default: ;
                endcase
            end
            // Junk in the upper DM bits so zero-extension is exercised.
            case (mem_sel[u])
                2'd1:    mem_rdata[u] <= rf[u][mem_addr[u][4:0]];
                2'd2:    mem_rdata[u] <= {24'hA5A5A5, dm[u][mem_addr[u]]};
                default: mem_rdata[u] <= 32'hDEAD_BEEF;
            endcase
            done_q[u] <= done[u];
            if (done[u] && !done_q[u]) done_rises[u] <= done_rises[u] + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic new_beats();
        for (int n = 0; n < N_ALL; n++) beats[n] = $urandom;
    endtask

    task automatic do_start(input int u);
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
    endtask

    task automatic do_load(input int u, input int gap, input int limit);
        int n = 0;
        bit v;
        for (int g = 0; g < 4000 && n < limit; g++) begin
            v = ($urandom_range(99) >= gap);
            ld_valid[u] = v;
            ld_data[u]  = beats[n];
            @(negedge clk);
            chk("ld_ready", 64'(ld_ready[u]), 64'(1));
            chk("ld_we", 64'(mem_we[u]), 64'(v));
            if (v) begin
                chk("ld_sel", 64'(mem_sel[u]), 64'(n < N_IM ? 0 : (n < N_IM + N_RF ? 1 : 2)));
                chk("ld_addr", 64'(mem_addr[u]),
                    64'(n < N_IM ? n : (n < N_IM + N_RF ? n - N_IM : n - N_IM - N_RF)));
                chk("ld_wdata", 64'(mem_wdata[u]), 64'(beats[n]));
            end
            @(posedge clk); #1;
            if (v) n++;
        end
        ld_valid[u] = 1'b0;
        chk("ld_beats", 64'(n), 64'(limit));
    endtask

    task automatic do_run(input int u, input int maxc, input bit pulse);
        int mpc = 0, mc = 0, msteps = 0, npc;
        bit mto = 1'b0;
        int cycles = 0, steps = 0;
        logic [31:0] first_pc = 32'd0, prev = 32'd0;
        // Reference: PC starts at 0, follows the CPU each cycle, run stops once
        // PC >= 124 or after cycle number maxc-1 (budget exit flags timeout).
        for (int i = 0; i < 5000; i++) begin
            if (mpc >= N_IM - 4) begin mto = 1'b0; break; end
            if (mc == maxc - 1) begin mto = 1'b1; break; end
            npc = (u == 0) ? mpc + 4 : 8;
            if (npc != mpc) msteps++;
            mpc = npc;
            mc++;
        end
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (!cpu_run[u]) break;
            if (cycles == 0) first_pc = cpu_pc_out[u];
            else if (cpu_pc_out[u] != prev) steps++;
            prev = cpu_pc_out[u];
            cycles++;
            chk("run_we", 64'(mem_we[u]), 64'(0));
            if (pulse && cycles == 5) start[u] = 1'b1;
            @(posedge clk); #1;
            start[u] = 1'b0;
        end
        chk("run_cycles", 64'(cycles), 64'(mc + 1));
        chk("run_pc_steps", 64'(steps), 64'(msteps));
        chk("run_first_pc", 64'(first_pc), 64'(0));
        chk("run_exit_pc", 64'(cpu_pc_out[u]), 64'(mpc));
        chk("run_timeout", 64'(timeout[u]), 64'(mto));
        chk("run_exit_busy", 64'(busy[u]), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_dump(input int u, input int rdy_pct);
        int k = 0;
        bit prev_hs = 1'b0, prev_wait = 1'b0, r;
        logic [31:0] prev_data = 32'd0, expv;
        for (int g = 0; g < 3000 && k < N_RF + N_DM; g++) begin
            @(negedge clk);
            if (prev_hs) chk("dump_gap", 64'(dp_valid[u]), 64'(0));
            chk("dump_we", 64'(mem_we[u] | cpu_run[u]), 64'(0));
            if (dp_valid[u]) begin
                // RF words go out whole, DM bytes zero-extended; beats[N_IM+k]
                // is the k-th dumped entry in both cases.
                expv = (k < N_RF) ? beats[N_IM + k] : {24'h0, beats[N_IM + k][7:0]};
                chk("dump_data", 64'(dp_data[u]), 64'(expv));
                chk("dump_sel", 64'(mem_sel[u]), 64'(k < N_RF ? 1 : 2));
                if (prev_wait) chk("dump_hold", 64'(dp_data[u]), 64'(prev_data));
            end
            r = ($urandom_range(99) < rdy_pct);
            dp_ready[u] = r;
            prev_hs   = dp_valid[u] && r;
            prev_wait = dp_valid[u] && !r;
            prev_data = dp_data[u];
            if (prev_hs) k++;
            @(posedge clk); #1;
        end
        dp_ready[u] = 1'b0;
        chk("dump_beats", 64'(k), 64'(N_RF + N_DM));
        @(negedge clk);
        chk("done_high", 64'(done[u]), 64'(1));
        chk("done_busy", 64'(busy[u]), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic full_cycle(input int u, input int gap, input int rdy, input bit pulse);
        int w0, d0;
        new_beats();
        w0 = wr_cnt[u];
        d0 = done_rises[u];
        do_start(u);
        do_load(u, gap, N_ALL);
        chk("load_writes", 64'(wr_cnt[u] - w0), 64'(N_ALL));
        do_run(u, (u == 0) ? 1024 : 16, pulse);
        do_dump(u, rdy);
        chk("done_once", 64'(done_rises[u] - d0), 64'(1));
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        lv;
        logic [31:0] ld;
        logic        e_busy;
        logic        e_rdy;
        logic        e_we;
        logic [1:0]  e_sel;
        logic [6:0]  e_addr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // rst  st  lv  ld             busy rdy we sel addr
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 2'd3, 7'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 2'd3, 7'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 2'd3, 7'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h4444_4444, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h5555_55A5, 1'b1, 1'b1, 1'b1, 2'd0, 7'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h6666_6666, 1'b1, 1'b1, 1'b0, 2'd0, 7'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h7777_775A, 1'b1, 1'b1, 1'b1, 2'd0, 7'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 2'd3, 7'd0};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; ld_valid[u] = 1'b0; ld_data[u] = 32'd0; dp_ready[u] = 1'b0;
        end
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            rst_n       = tbl[i].rst;
            start[0]    = tbl[i].st;
            ld_valid[0] = tbl[i].lv;
            ld_data[0]  = tbl[i].ld;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), 64'(busy[0]), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_ready", i), 64'(ld_ready[0]), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_we", i), 64'(mem_we[0]), 64'(tbl[i].e_we));
            chk($sformatf("vec%0d_sel", i), 64'(mem_sel[0]), 64'(tbl[i].e_sel));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr[0]), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata[0]), 64'(tbl[i].ld));
            chk($sformatf("vec%0d_quiet", i),
                64'({cpu_run[0], dp_valid[0], done[0], timeout[0]}), 64'(0));
            chk($sformatf("vec%0d_pc", i), 64'(cpu_pc_out[0]), 64'(0));
            @(posedge clk); #1;
        end
        rst_n = 1'b1; start[0] = 1'b0; ld_valid[0] = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of LOAD_RF.
        new_beats();
        do_start(0);
        do_load(0, 20, 140);
        ld_valid[0] = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy[0]), 64'(0));
        chk("rst_we", 64'(mem_we[0]), 64'(0));
        chk("rst_sel", 64'(mem_sel[0]), 64'(3));
        chk("rst_ready", 64'(ld_ready[0]), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; ld_valid[0] = 1'b0;
        @(posedge clk); #1;

        // Full runs on instance 0 (second one starts from DONE), start pulsed mid-RUN.
        full_cycle(0, 30, 50, 1'b1);
        full_cycle(0, 10, 70, 1'b0);

        // Budget exit on instance 1; timeout stays until the next start.
        full_cycle(1, 0, 100, 1'b0);
        @(negedge clk);
        chk("to_sticky", 64'(timeout[1]), 64'(1));
        @(posedge clk); #1;
        do_start(1);
        @(negedge clk);
        chk("to_cleared", 64'(timeout[1]), 64'(0));
        chk("restart_ready", 64'(ld_ready[1]), 64'(1));
        chk("restart_sel", 64'(mem_sel[1]), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
